execute_pipe: RTL and testbench

//  Registered, handshaked execute stage; successor to the combinational Execute block.

---
 rtl/exe_pkg.sv | 27 ++
 rtl/exe_mul_iter.sv | 72 +++++++
 rtl/execute_pipe.sv | 153 +++++++++++++++
 tb/tb_execute_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared types for the registered execute stage: ALU opcodes, branch conditions
// and the stage's IDLE/MUL state encoding.
package exe_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_INC   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_XOR   = 3'd5,
    ALU_MUL   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    BR_NZSUM = 2'd0,
    BR_GTU   = 2'd1,
    BR_EQ    = 2'd2,
    BR_LTS   = 2'd3
  } br_cond_t;

  typedef logic [0:0] exe_state_t;
  localparam exe_state_t IDLE = 1'b0;
  localparam exe_state_t MUL  = 1'b1;

endpackage

// File: rtl/exe_mul_iter.sv
// Radix-2 shift-add multiplier: operands latch on start, then one iteration per
// cycle for DATAW cycles; done pulses on the final iteration with prod valid.
module exe_mul_iter #(
  parameter int unsigned DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  output logic             done,
  output logic [DATAW-1:0] prod
);

  localparam int unsigned CW = $clog2(DATAW);

  logic             busy_q,   busy_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [DATAW-1:0] mcand_q,  mcand_d;
  logic [DATAW-1:0] mplier_q, mplier_d;
  logic [DATAW-1:0] acc_q,    acc_d;
  logic [DATAW-1:0] acc_next;
  logic             last;

  // The final partial product is folded in combinationally so the result is
  // available on the same edge as the last iteration.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last     = busy_q && (cnt_q == CW'(DATAW - 1));
  assign done     = last;
  assign prod     = acc_next;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// Registered, handshaked execute stage: single-cycle ALU/imm-load/branch ops,
// iterative multiply, output back-pressure and flush. One op in flight.
module execute_pipe
  import exe_pkg::*;
#(
  parameter int unsigned DATAW = 32,
  parameter int unsigned PCW   = 32,
  parameter int unsigned IMMW  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          alu_op,
  input  logic             use_imm,
  input  logic [1:0]       shift_dist,
  input  logic             branch_in,
  input  br_cond_t         br_cond,
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  input  logic [IMMW-1:0]  imm,
  input  logic [PCW-1:0]   PC_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] ex_out,
  output logic             branch_out,
  output logic [PCW-1:0]   PC_out
);

  exe_state_t       state_q, state_d;
  logic             valid_q, valid_d;
  logic [DATAW-1:0] ex_q,    ex_d;
  logic             br_q,    br_d;
  logic [PCW-1:0]   pc_q,    pc_d;
  logic             brh_q,   brh_d;
  logic [PCW-1:0]   pch_q,   pch_d;

  logic             accept, is_mul, mul_done;
  logic [DATAW-1:0] mul_prod, alu_res, imm_ext, sum;
  logic             cond_hit;
  logic [PCW-1:0]   pc_tgt;

  assign in_ready = !rst && (state_q == IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = !use_imm && (alu_op == ALU_MUL);

  assign sum     = a + b;
  assign imm_ext = {{(DATAW-8){1'b0}}, imm[7:0]};
  assign pc_tgt  = PC_in + PCW'($signed(imm));

  always_comb begin
    alu_res = '0;
    if (use_imm) begin
      alu_res = imm_ext << (32'(shift_dist) * (DATAW / 4));
    end else begin
      unique case (alu_op)
        ALU_ADD:   alu_res = sum;
        ALU_INC:   alu_res = a + DATAW'(1);
        ALU_SUB:   alu_res = a - b;
        ALU_AND:   alu_res = a & b;
        ALU_OR:    alu_res = a | b;
        ALU_XOR:   alu_res = a ^ b;
        ALU_MUL:   alu_res = '0;
        ALU_PASSB: alu_res = b;
      endcase
    end
  end

  always_comb begin
    cond_hit = 1'b0;
    unique case (br_cond)
      BR_NZSUM: cond_hit = (sum != '0);
      BR_GTU:   cond_hit = (a > b);
      BR_EQ:    cond_hit = (a == b);
      BR_LTS:   cond_hit = ($signed(a) < $signed(b));
    endcase
  end

  exe_mul_iter #(.DATAW(DATAW)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_mul && !flush),
    .abort (flush),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ex_d    = ex_q;
    br_d    = br_q;
    pc_d    = pc_q;
    brh_d   = brh_q;
    pch_d   = pch_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (state_q == MUL) begin
      if (mul_done) begin
        ex_d    = mul_prod;
        br_d    = brh_q;
        pc_d    = pch_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
    end else if (accept) begin
      // Branch result and target are held aside so a pending output is not
      // disturbed while the multiply runs.
      if (is_mul) begin
        brh_d   = branch_in && cond_hit;
        pch_d   = pc_tgt;
        state_d = MUL;
      end else begin
        ex_d    = alu_res;
        br_d    = branch_in && cond_hit;
        pc_d    = pc_tgt;
        valid_d = 1'b1;
      end
    end
    if (flush) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ex_q    <= '0;
      br_q    <= 1'b0;
      pc_q    <= '0;
      brh_q   <= 1'b0;
      pch_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ex_q    <= ex_d;
      br_q    <= br_d;
      pc_q    <= pc_d;
      brh_q   <= brh_d;
      pch_q   <= pch_d;
    end
  end

  assign out_valid  = valid_q;
  assign ex_out     = ex_q;
  assign branch_out = br_q;
  assign PC_out     = pc_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: directed scenarios plus randomized ops with
// random consumer back-pressure, checked against an arithmetic reference model.
module tb_execute_pipe;
  import exe_pkg::*;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int IW = 11;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, use_imm, branch_in;
  logic          out_valid, out_ready, branch_out;
  logic [2:0]    op;
  logic [1:0]    sd, cond;
  logic [DW-1:0] a, b, ex_out;
  logic [IW-1:0] imm;
  logic [PW-1:0] pc_in, pc_out;

  always #5 clk = ~clk;

  execute_pipe #(.DATAW(DW), .PCW(PW), .IMMW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op_t'(op)),
    .use_imm    (use_imm),
    .shift_dist (sd),
    .branch_in  (branch_in),
    .br_cond    (br_cond_t'(cond)),
    .a          (a),
    .b          (b),
    .imm        (imm),
    .PC_in      (pc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ex_out     (ex_out),
    .branch_out (branch_out),
    .PC_out     (pc_out)
  );

  typedef struct {
    logic [31:0] ex;
    logic        br;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rdone = 1'b0;

  function automatic exp_t model(input logic [2:0] o, input logic ui, input logic [1:0] s,
                                 input logic bi, input logic [1:0] c, input logic [31:0] x,
                                 input logic [31:0] y, input logic [10:0] im,
                                 input logic [31:0] pc);
    exp_t        e;
    logic [63:0] full;
    logic [31:0] im8;
    logic        cnd;
    im8  = {24'd0, im[7:0]};
    full = {32'd0, x} * {32'd0, y};
    if (ui) e.ex = im8 << (8 * s);
    else begin
      case (o)
        3'd0:    e.ex = x + y;
        3'd1:    e.ex = x + 32'd1;
        3'd2:    e.ex = x - y;
        3'd3:    e.ex = x & y;
        3'd4:    e.ex = x | y;
        3'd5:    e.ex = x ^ y;
        3'd6:    e.ex = full[31:0];
        default: e.ex = y;
      endcase
    end
    case (c)
      2'd0:    cnd = ((x + y) != 32'd0);
      2'd1:    cnd = (x > y);
      2'd2:    cnd = (x == y);
      default: cnd = ($signed(x) < $signed(y));
    endcase
    e.br = bi && cnd;
    e.pc = pc + {{21{im[10]}}, im};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic ui, input logic [1:0] s,
                       input logic bi, input logic [1:0] c, input logic [31:0] x,
                       input logic [31:0] y, input logic [10:0] im, input logic [31:0] pc);
    bit ok;
    op = o; use_imm = ui; sd = s; branch_in = bi; cond = c;
    a = x; b = y; imm = im; pc_in = pc;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!flush) sb.push_back(model(o, ui, s, bi, c, x, y, im, pc));
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got in_ready=0 expected accept within 300 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer is matched against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got ex_out=%0h expected no output", ex_out);
        end else begin
          e = sb.pop_front();
          chk("sb_ex", 64'(ex_out), 64'(e.ex));
          chk("sb_br", 64'(branch_out), 64'(e.br));
          chk("sb_pc", 64'(pc_out), 64'(e.pc));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    exp_t dummy;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; use_imm = 1'b0; sd = '0; branch_in = 1'b0; cond = '0;
    a = '0; b = '0; imm = '0; pc_in = '0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ex_out", 64'(ex_out), 64'd0);
    chk("rst_branch_out", 64'(branch_out), 64'd0);
    chk("rst_pc_out", 64'(pc_out), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // ADD with negative immediate offset
    issue(3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd5, 32'd7, 11'h7FF, 32'h100);
    @(negedge clk);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_ex", 64'(ex_out), 64'd12);
    chk("add_pc", 64'(pc_out), 64'hFF);
    tick();

    // Immediate load in top lane; MUL opcode must not go multi-cycle
    issue(3'd6, 1'b1, 2'd3, 1'b0, 2'd0, 32'h1234, 32'h55, 11'h0AB, 32'h0);
    @(negedge clk);
    chk("imm_valid", 64'(out_valid), 64'd1);
    chk("imm_ex", 64'(ex_out), 64'hAB000000);
    tick();

    // Multi-cycle multiply
    issue(3'd6, 1'b0, 2'd0, 1'b0, 2'd0, 32'hFFFFFFFF, 32'd3, 11'h0, 32'h0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (!in_ready) cnt++;
    end
    chk("mul_valid", 64'(out_valid), 64'd1);
    chk("mul_busy_cycles", 64'(cnt), 64'd32);
    chk("mul_ex", 64'(ex_out), 64'hFFFFFFFD);
    tick();

    // Branch conditions
    issue(3'd0, 1'b0, 2'd0, 1'b1, 2'd3, 32'hFFFFFFFF, 32'd1, 11'h010, 32'h200);
    @(negedge clk);
    chk("br_lts", 64'(branch_out), 64'd1);
    tick();
    issue(3'd0, 1'b0, 2'd0, 1'b1, 2'd0, 32'd1, 32'hFFFFFFFF, 11'h010, 32'h200);
    @(negedge clk);
    chk("br_nzsum", 64'(branch_out), 64'd0);
    tick();

    // Back-pressure hold, then drain with a back-to-back accept
    out_ready = 1'b0;
    issue(3'd2, 1'b0, 2'd0, 1'b0, 2'd0, 32'd100, 32'd1, 11'h0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_ex", 64'(ex_out), 64'd99);
    end
    tick();
    out_ready = 1'b1;
    issue(3'd4, 1'b0, 2'd0, 1'b0, 2'd0, 32'hF0, 32'h0F, 11'h0, 32'h0);
    @(negedge clk);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_ex", 64'(ex_out), 64'hFF);
    tick();

    // Flush mid-multiply
    issue(3'd6, 1'b0, 2'd0, 1'b0, 2'd0, 32'd7, 32'd9, 11'h0, 32'h0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    dummy = sb.pop_back();
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_output", 64'(seen), 64'd0);
    tick();

    // Request presented together with flush is dropped
    flush = 1'b1;
    issue(3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd1, 32'd2, 11'h0, 32'h0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_drop", 64'(out_valid), 64'd0);
    tick();

    // Reset mid-multiply
    issue(3'd6, 1'b0, 2'd0, 1'b1, 2'd2, 32'd3, 32'd3, 11'h3, 32'h40);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rstmul_in_ready", 64'(in_ready), 64'd0);
    chk("rstmul_valid", 64'(out_valid), 64'd0);
    chk("rstmul_ex", 64'(ex_out), 64'd0);
    chk("rstmul_br", 64'(branch_out), 64'd0);
    chk("rstmul_pc", 64'(pc_out), 64'd0);
    tick();
    rst = 1'b0;
    dummy = sb.pop_back();
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rstmul_no_output", 64'(seen), 64'd0);
    tick();

    // Randomized ops with random consumer back-pressure
    fork
      begin
        logic [31:0] ra, rb;
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          ra = $urandom();
          rb = ($urandom_range(0, 5) == 0) ? ra : $urandom();
          issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), ra, rb, 11'($urandom()), $urandom());
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join

    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
